// File: rtl/r_file.sv
// ---------------------------------------------------------------------------
// r_file : RV32I register file, two combinational read ports, one write port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module r_file #(
  parameter int dataWidth    = 32,
  parameter int AddressWidth = 5
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    RFwrite,
  input  logic [AddressWidth-1:0] RegA,
  input  logic [AddressWidth-1:0] RegB,
  input  logic [AddressWidth-1:0] RegW,
  input  logic [dataWidth-1:0]    dataW,
  output logic [dataWidth-1:0]    dataA,
  output logic [dataWidth-1:0]    dataB
);

  localparam int DEPTH = 2 ** AddressWidth;

  logic [dataWidth-1:0] regs_q [DEPTH];
  logic [dataWidth-1:0] regs_d [DEPTH];

  // Entry 0 is pinned to zero in the next-state so x0 never holds data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    regs_d[0] = '0;
    if (RFwrite && (RegW != '0)) begin
      regs_d[RegW] = dataW;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No write bypass: reads always reflect the currently stored value.
  always_comb begin
    dataA = (RegA == '0) ? '0 : regs_q[RegA];
    dataB = (RegB == '0) ? '0 : regs_q[RegB];
  end

endmodule

`default_nettype wire

// File: tb/tb_r_file.sv
// ---------------------------------------------------------------------------
// tb_r_file : self-checking scoreboard bench for r_file
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_r_file;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;

  logic          Clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          RFwrite = 1'b0;
  logic [AW-1:0] RegA    = '0;
  logic [AW-1:0] RegB    = '0;
  logic [AW-1:0] RegW    = '0;
  logic [DW-1:0] dataW   = '0;
  logic [DW-1:0] dataA;
  logic [DW-1:0] dataB;

  r_file #(.dataWidth(DW), .AddressWidth(AW)) dut (
    .Clk     (Clk),
    .reset   (reset),
    .RFwrite (RFwrite),
    .RegA    (RegA),
    .RegB    (RegB),
    .RegW    (RegW),
    .dataW   (dataW),
    .dataA   (dataA),
    .dataB   (dataB)
  );

  always #5 Clk = ~Clk;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Drive read indices and push the model's expectation for both ports.
  task automatic drive_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
    RegA = a;
    RegB = b;
    exp_q.push_back((a == '0) ? '0 : model[a]);
    exp_q.push_back((b == '0) ? '0 : model[b]);
  endtask

  task automatic compare_read(input string tag);
    logic [DW-1:0] ea, eb;
    #1;
    ea = exp_q.pop_front();
    eb = exp_q.pop_front();
    check_val({tag, "_A"}, dataA, ea);
    check_val({tag, "_B"}, dataB, eb);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic en);
    @(negedge Clk);
    RFwrite = en;
    RegW    = addr;
    dataW   = data;
    @(posedge Clk);
    #1;
    if (en && addr != '0) model[addr] = data;
    RFwrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", n_checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    #2 reset = 1'b0;
    drive_read(5, 31);
    compare_read("reset_state");

    // Writes attempted while reset is low must be dropped.
    @(negedge Clk);
    RFwrite = 1'b1; RegW = 5'd3; dataW = 32'hCAFE_F00D;
    @(posedge Clk);
    #1;
    RFwrite = 1'b0;
    drive_read(3, 3);
    compare_read("rst_blocks_wr");
    @(negedge Clk);
    reset = 1'b1;

    // Asynchronous clear between edges.
    wr(5, 32'hDEAD_BEEF, 1'b1);
    drive_read(5, 0);
    compare_read("x5_written");
    @(negedge Clk);
    reset = 1'b0;
    model_clear();
    drive_read(5, 5);
    compare_read("async_clr");
    reset = 1'b1;

    // x0 hardwire and basic write.
    wr(0, 32'h0000_0003, 1'b1);
    drive_read(0, 0);
    compare_read("x0_hardwire");
    wr(2, 32'h0000_0003, 1'b1);
    drive_read(2, 0);
    compare_read("basic_wr");

    // No bypass: old value visible until the capturing edge.
    @(negedge Clk);
    RFwrite = 1'b1; RegW = 5'd2; dataW = 32'h1234_5678;
    drive_read(2, 2);
    compare_read("no_bypass_pre");
    @(posedge Clk);
    #1;
    model[2] = 32'h1234_5678;
    RFwrite = 1'b0;
    drive_read(2, 0);
    compare_read("no_bypass_post");
    wr(2, 32'hFFFF_FFFF, 1'b0);
    drive_read(2, 2);
    compare_read("en_low_hold");

    // Full sweep, port B addressed in reverse to exercise both decoders.
    for (int i = 1; i < DEPTH; i++) wr(AW'(i), DW'(i) * 32'h0101_0101, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      drive_read(AW'(i), AW'(DEPTH - 1 - i));
      compare_read($sformatf("sweep_%0d", i));
    end

    wr(17, 32'hA5A5_A5A5, 1'b1);
    drive_read(17, 17);
    compare_read("dual_same");

    // Random traffic against the model.
    for (int k = 0; k < 60; k++) begin
      wr(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      drive_read(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
      compare_read($sformatf("rand_%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
